// File: rtl/write_buffer.sv
// write_buffer: posted-write FIFO between the L1 cache RAM-side Avalon master
// and main memory. Stores are accepted with no wait states and drained to RAM
// in order; reads go to RAM one at a time once ordering against queued writes
// is safe.
//
// Ports:
//   clk, reset (async, active-low)
//   cache side : read_cache, write_cache, addr_cache, byteenable_cache,
//                writedata_cache, readdata_cache, waitrequest_cache
//   RAM side   : read_ram, write_ram, addr_ram, byteenable_ram, writedata_ram,
//                readdata_ram, waitrequest_ram
//   empty      : no queued entries and FSM idle
//
// Build option READ_BYPASS_EN: a read may overtake queued writes when none of
// them targets the same word; otherwise reads wait for an empty FIFO.
module write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_cache,
   input  logic        write_cache,
   input  logic [31:0] addr_cache,
   input  logic [3:0]  byteenable_cache,
   input  logic [31:0] writedata_cache,
   output logic [31:0] readdata_cache,
   output logic        waitrequest_cache,
   output logic        read_ram,
   output logic        write_ram,
   output logic [31:0] addr_ram,
   output logic [3:0]  byteenable_ram,
   output logic [31:0] writedata_ram,
   input  logic [31:0] readdata_ram,
   input  logic        waitrequest_ram,
   output logic        empty
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;
   state_t state, next_state;
   logic [31:0] fifo_addr [DEPTH];
   logic [31:0] fifo_data [DEPTH];
   logic [3:0]  fifo_be   [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic full, push, pop, read_ok;
   // Full is judged on the registered count, so a pop in the same cycle
   // does not let a stalled write in early.
   assign full = count == (AW+1)'(DEPTH);
   assign push = write_cache && !full;
   assign pop = state == DRAIN && !waitrequest_ram;
   assign empty = count == '0 && state == IDLE;
   // A simultaneous write wins; the read is simply held off that cycle.
   assign waitrequest_cache = write_cache ? full : (read_cache && state != RESP);
`ifdef READ_BYPASS_EN
   logic [DEPTH-1:0] hit;
   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      logic [AW-1:0] off;
      // Slot i holds a live entry when its distance from the head is below count.
      assign off = AW'(i) - rd_ptr;
      assign hit[i] = {1'b0, off} < count && fifo_addr[i][31:2] == addr_cache[31:2];
   end
   assign read_ok = read_cache && !write_cache && !(|hit);
`else
   assign read_ok = read_cache && !write_cache && count == '0;
`endif
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = read_ok ? READ : (count != '0 ? DRAIN : IDLE);
         DRAIN:   next_state = waitrequest_ram ? DRAIN : IDLE;
         READ:    next_state = waitrequest_ram ? READ : RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= addr_cache;
         fifo_data[wr_ptr] <= writedata_cache;
         fifo_be[wr_ptr] <= byteenable_cache;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end
   // RAM-side signals are registered and only change on transaction start or
   // completion, which keeps them stable while the RAM stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         read_ram <= 1'b0;
         write_ram <= 1'b0;
         addr_ram <= '0;
         byteenable_ram <= '0;
         writedata_ram <= '0;
         readdata_cache <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && next_state == READ) begin
            read_ram <= 1'b1;
            addr_ram <= addr_cache;
            byteenable_ram <= byteenable_cache;
         end
         if (state == IDLE && next_state == DRAIN) begin
            write_ram <= 1'b1;
            addr_ram <= fifo_addr[rd_ptr];
            byteenable_ram <= fifo_be[rd_ptr];
            writedata_ram <= fifo_data[rd_ptr];
         end
         if (pop) write_ram <= 1'b0;
         if (state == READ && !waitrequest_ram) begin
            read_ram <= 1'b0;
            readdata_cache <= readdata_ram;
         end
      end
   end
endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed self-checking bench for write_buffer with a small
// byte-lane RAM model that logs every retired write.
module tb_write_buffer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        read_cache = 1'b0, write_cache = 1'b0;
   logic [31:0] addr_cache = '0, writedata_cache = '0;
   logic [3:0]  byteenable_cache = '0;
   logic [31:0] readdata_cache;
   logic        waitrequest_cache;
   logic        read_ram, write_ram;
   logic [31:0] addr_ram, writedata_ram, readdata_ram;
   logic [3:0]  byteenable_ram;
   logic        waitrequest_ram = 1'b0;
   logic        empty;
   int errors = 0, checks = 0;
   logic [31:0] mem [64];
   logic [31:0] wa[$], wd[$];
   int wlog_at_read = -1;
   bit rd_seen = 1'b0;

   write_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .read_cache(read_cache), .write_cache(write_cache), .addr_cache(addr_cache),
      .byteenable_cache(byteenable_cache), .writedata_cache(writedata_cache),
      .readdata_cache(readdata_cache), .waitrequest_cache(waitrequest_cache),
      .read_ram(read_ram), .write_ram(write_ram), .addr_ram(addr_ram),
      .byteenable_ram(byteenable_ram), .writedata_ram(writedata_ram),
      .readdata_ram(readdata_ram), .waitrequest_ram(waitrequest_ram), .empty(empty)
   );

   always #5 clk = ~clk;
   assign readdata_ram = mem[addr_ram[7:2]];

   always @(posedge clk) begin
      if (reset && write_ram && !waitrequest_ram) begin
         for (int b = 0; b < 4; b++)
            if (byteenable_ram[b]) mem[addr_ram[7:2]][8*b +: 8] = writedata_ram[8*b +: 8];
         wa.push_back(addr_ram);
         wd.push_back(writedata_ram);
      end
      if (reset && read_ram && !rd_seen) begin
         rd_seen = 1'b1;
         wlog_at_read = wa.size();
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, output int w);
      write_cache = 1'b1; addr_cache = a; writedata_cache = d; byteenable_cache = be; w = 0;
      @(negedge clk);
      while (waitrequest_cache && w < 100) begin @(negedge clk); w++; end
      @(posedge clk); #1;
      write_cache = 1'b0;
   endtask

   task automatic cread(input logic [31:0] a, output logic [31:0] d, output int c);
      rd_seen = 1'b0; wlog_at_read = -1;
      read_cache = 1'b1; addr_cache = a; byteenable_cache = 4'hF; c = 0;
      @(negedge clk);
      while (waitrequest_cache && c < 100) begin @(negedge clk); c++; end
      d = readdata_cache;
      @(posedge clk); #1;
      read_cache = 1'b0;
   endtask

   task automatic wait_empty(output int n);
      n = 0;
      @(negedge clk);
      while (!empty && n < 200) begin @(negedge clk); n++; end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int w;
      repeat (2) @(posedge clk); #1;
      checks++; if ({empty, write_ram, read_ram} !== 3'b100) begin errors++; $display("FAIL reset_flags: empty/write/read=%b expected 100", {empty, write_ram, read_ram}); end
      checks++; if (addr_ram !== 32'h0 || writedata_ram !== 32'h0 || byteenable_ram !== 4'h0) begin errors++; $display("FAIL reset_ram_bus: addr=%h data=%h be=%h expected zeros", addr_ram, writedata_ram, byteenable_ram); end
      checks++; if (readdata_cache !== 32'h0 || waitrequest_cache !== 1'b0) begin errors++; $display("FAIL reset_cache: rd=%h wait=%b expected 0/0", readdata_cache, waitrequest_cache); end
      reset = 1'b1;
      @(posedge clk); #1;
      waitrequest_ram = 1'b1;
      for (int i = 0; i < 3; i++) cwrite(32'(4*i), 32'hEE00 + 32'(i), 4'hF, w);
      checks++; if ({write_ram, empty} !== 2'b10) begin errors++; $display("FAIL pre_reset_drain: write_ram/empty=%b expected 10", {write_ram, empty}); end
      @(negedge clk); reset = 1'b0; #1;
      checks++; if ({write_ram, empty, waitrequest_cache} !== 3'b010) begin errors++; $display("FAIL mid_drain_reset: write/empty/wait=%b expected 010", {write_ram, empty, waitrequest_cache}); end
      @(posedge clk); #1;
      reset = 1'b1; waitrequest_ram = 1'b0;
      wa.delete(); wd.delete();
      repeat (5) @(posedge clk); #1;
      checks++; if (wa.size() !== 0 || empty !== 1'b1) begin errors++; $display("FAIL reset_abandon: writes=%0d empty=%b expected 0/1", wa.size(), empty); end
   endtask

   task automatic test_fill();
      int w, n;
      wa.delete(); wd.delete();
      waitrequest_ram = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cwrite(32'(16 + 4*i), 32'hA0 + 32'(i), 4'hF, w);
         checks++; if (w !== 0) begin errors++; $display("FAIL fill_accept%0d: wait cycles=%0d expected 0", i, w); end
      end
      checks++; if (write_ram !== 1'b1 || addr_ram !== 32'd16) begin errors++; $display("FAIL fill_hold: write_ram=%b addr=%h expected 1/10", write_ram, addr_ram); end
      write_cache = 1'b1; addr_cache = 32'd32; writedata_cache = 32'hA4; byteenable_cache = 4'hF;
      repeat (3) @(negedge clk);
      checks++; if (waitrequest_cache !== 1'b1) begin errors++; $display("FAIL fifth_stall: wait=%b expected 1", waitrequest_cache); end
      @(posedge clk); #1; waitrequest_ram = 1'b0;
      @(negedge clk);
      checks++; if (waitrequest_cache !== 1'b1) begin errors++; $display("FAIL pop_no_unblock: wait=%b expected 1", waitrequest_cache); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (waitrequest_cache !== 1'b0) begin errors++; $display("FAIL fifth_accept: wait=%b expected 0", waitrequest_cache); end
      @(posedge clk); #1; write_cache = 1'b0;
      wait_empty(n);
      checks++; if (wa.size() !== 5) begin errors++; $display("FAIL fill_count: writes=%0d expected 5", wa.size()); end
      else for (int i = 0; i < 5; i++) begin
         checks++; if (wa[i] !== 32'(16 + 4*i) || wd[i] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL fill_order%0d: addr=%h data=%h expected %h/%h", i, wa[i], wd[i], 16 + 4*i, 32'hA0 + i); end
      end
   endtask

   task automatic test_read_after_write();
      int w, c;
      logic [31:0] d;
      wa.delete(); wd.delete();
      waitrequest_ram = 1'b1;
      cwrite(32'd40, 32'h55, 4'b0011, w);
      fork
         cread(32'd40, d, c);
         begin repeat (4) @(posedge clk); #1; waitrequest_ram = 1'b0; end
      join
      checks++; if (d !== 32'h1000_0055 || c >= 100) begin errors++; $display("FAIL raw_data: got %h expected 10000055 (cycles %0d)", d, c); end
      checks++; if (wlog_at_read !== 1) begin errors++; $display("FAIL raw_order: writes before read=%0d expected 1", wlog_at_read); end
   endtask

   task automatic test_read_latency();
      int c;
      logic [31:0] d;
      cread(32'd64, d, c);
      checks++; if (d !== 32'h1000_0010) begin errors++; $display("FAIL lat_data: got %h expected 10000010", d); end
      checks++; if (c !== 2) begin errors++; $display("FAIL lat_cycles: got %0d expected 2", c); end
   endtask

   task automatic test_read_vs_queue();
      int w, c, n, exp_at;
      logic [31:0] d;
`ifdef READ_BYPASS_EN
      exp_at = 1;
`else
      exp_at = 2;
`endif
      wa.delete(); wd.delete();
      waitrequest_ram = 1'b1;
      cwrite(32'd16, 32'hB0, 4'hF, w);
      cwrite(32'd20, 32'hB1, 4'hF, w);
      fork
         cread(32'd64, d, c);
         begin repeat (4) @(posedge clk); #1; waitrequest_ram = 1'b0; end
      join
      wait_empty(n);
      checks++; if (d !== 32'h1000_0010) begin errors++; $display("FAIL queue_read_data: got %h expected 10000010", d); end
      checks++; if (wlog_at_read !== exp_at) begin errors++; $display("FAIL queue_read_order: writes before read=%0d expected %0d", wlog_at_read, exp_at); end
      checks++; if (wa.size() !== 2 || wd[1] !== 32'hB1) begin errors++; $display("FAIL queue_writes: count=%0d expected 2 ending B1", wa.size()); end
   endtask

   task automatic test_back_to_back();
      int w, n;
      logic [31:0] ea [6];
      ea = '{32'd48, 32'd52, 32'd56, 32'd60, 32'd68, 32'd72};
      wa.delete(); wd.delete();
      waitrequest_ram = 1'b1;
      cwrite(ea[0], 32'hC0, 4'hF, w);
      cwrite(ea[1], 32'hC1, 4'hF, w);
      write_cache = 1'b1; addr_cache = ea[2]; writedata_cache = 32'hC2; waitrequest_ram = 1'b0;
      @(negedge clk);
      checks++; if (waitrequest_cache !== 1'b0) begin errors++; $display("FAIL pushpop_accept: wait=%b expected 0", waitrequest_cache); end
      @(posedge clk); #1;
      write_cache = 1'b0; waitrequest_ram = 1'b1;
      checks++; if (empty !== 1'b0 || wa.size() !== 1) begin errors++; $display("FAIL pushpop_state: empty=%b writes=%0d expected 0/1", empty, wa.size()); end
      cwrite(ea[3], 32'hC3, 4'hF, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL pushpop_room3: wait cycles=%0d expected 0", w); end
      cwrite(ea[4], 32'hC4, 4'hF, w);
      checks++; if (w !== 0) begin errors++; $display("FAIL pushpop_room4: wait cycles=%0d expected 0", w); end
      write_cache = 1'b1; addr_cache = ea[5]; writedata_cache = 32'hC5;
      repeat (2) @(negedge clk);
      checks++; if (waitrequest_cache !== 1'b1) begin errors++; $display("FAIL pushpop_full: wait=%b expected 1", waitrequest_cache); end
      @(posedge clk); #1; waitrequest_ram = 1'b0;
      n = 0;
      @(negedge clk);
      while (waitrequest_cache && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1; write_cache = 1'b0;
      wait_empty(n);
      checks++; if (wa.size() !== 6) begin errors++; $display("FAIL pushpop_count: writes=%0d expected 6", wa.size()); end
      else for (int i = 0; i < 6; i++) begin
         checks++; if (wa[i] !== ea[i] || wd[i] !== 32'hC0 + 32'(i)) begin errors++; $display("FAIL pushpop_order%0d: addr=%h data=%h expected %h/%h", i, wa[i], wd[i], ea[i], 32'hC0 + i); end
      end
   endtask

   task automatic test_wrap();
      int w, n, bad;
      wa.delete(); wd.delete();
      waitrequest_ram = 1'b0; bad = 0;
      for (int i = 0; i < 9; i++) begin
         cwrite(32'(128 + 4*i), 32'hD0 + 32'(i), 4'hF, w);
         if (w >= 100) bad++;
      end
      wait_empty(n);
      checks++; if (bad !== 0 || wa.size() !== 9) begin errors++; $display("FAIL wrap_count: timeouts=%0d writes=%0d expected 0/9", bad, wa.size()); end
      else for (int i = 0; i < 9; i++) begin
         checks++; if (wa[i] !== 32'(128 + 4*i) || wd[i] !== 32'hD0 + 32'(i)) begin errors++; $display("FAIL wrap_order%0d: addr=%h data=%h expected %h/%h", i, wa[i], wd[i], 128 + 4*i, 32'hD0 + i); end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
      test_reset();
      test_fill();
      test_read_after_write();
      test_read_latency();
      test_read_vs_queue();
      test_back_to_back();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
